// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
//   Sequential radix-2 Booth multiplier. Computes the full 2*WIDTH-bit product
//   of two WIDTH-bit operands, one add/subtract-and-shift step per clock.
//   A per-operation mode selects signed (two's complement) or unsigned.
//   Both operands are widened by one bit, so one signed Booth core serves
//   both modes. The widening bit is the operand MSB when signed and 0 when
//   unsigned. Start-to-done latency is WIDTH+2 clocks. A start presented in
//   the done cycle is accepted immediately.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset (abandons any operation)
//   start_i      request a multiply; sampled whenever not busy
//   is_signed_i  1 = operands are two's complement, 0 = unsigned
//   a_i          multiplicand (latched on acceptance)
//   b_i          multiplier (latched on acceptance)
//   busy_o       high while an operation is in progress
//   done_o       one-cycle pulse when product_o has just been updated
//   product_o    result; holds until the next done or reset
// -----------------------------------------------------------------------------
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 is_signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int EW = WIDTH + 1;           // extended operand width
  localparam int AW = WIDTH + 2;           // accumulator width
  localparam int CW = $clog2(WIDTH + 2);   // iteration counter width

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Widen an operand by one bit so that unsigned values stay positive
  // inside the signed Booth datapath.
  function automatic logic [EW-1:0] extend_op(input logic [WIDTH-1:0] v,
                                              input logic             sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  state_e               state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [EW-1:0]        q_q, q_d;
  logic                 q1_q, q1_d;
  logic [EW-1:0]        mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [AW-1:0]        mcand_wide_s;
  logic [AW-1:0]        sum_s;
  logic [AW-1:0]        shift_acc_s;
  logic [EW-1:0]        shift_q_s;
  logic                 shift_q1_s;
  logic [CW-1:0]        cnt_dec_s;
  logic [AW+EW-1:0]     full_s;

  // One Booth step: add/subtract per {Q[0],Q_1}, then arithmetic right shift.
  always_comb begin
    mcand_wide_s = {mcand_q[EW-1], mcand_q};
    case ({q_q[0], q1_q})
      2'b01:   sum_s = acc_q + mcand_wide_s;
      2'b10:   sum_s = acc_q - mcand_wide_s;
      default: sum_s = acc_q;
    endcase
    shift_acc_s = {sum_s[AW-1], sum_s[AW-1:1]};
    shift_q_s   = {sum_s[0], q_q[EW-1:1]};
    shift_q1_s  = q_q[0];
    cnt_dec_s   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    // {ACC,Q} after the step holds the exact (W+1)x(W+1) product; the low
    // 2*WIDTH bits are the result for both modes.
    full_s      = {shift_acc_s, shift_q_s};
  end

  // Next-state and datapath control; busy/done are computed one cycle ahead
  // so that they leave the block as plain registers.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    prod_d  = prod_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_CALC;
          acc_d   = {AW{1'b0}};
          q_d     = extend_op(b_i, is_signed_i);
          q1_d    = 1'b0;
          mcand_d = extend_op(a_i, is_signed_i);
          cnt_d   = CW'(WIDTH + 1);
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d = shift_acc_s;
        q_d   = shift_q_s;
        q1_d  = shift_q1_s;
        cnt_d = cnt_dec_s;
        if (cnt_dec_s == {CW{1'b0}}) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          prod_d  = full_s[2*WIDTH-1:0];
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= {AW{1'b0}};
      q_q     <= {EW{1'b0}};
      q1_q    <= 1'b0;
      mcand_q <= {EW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= {(2*WIDTH){1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
//   Three instances (WIDTH 4, 8, 16) share clock, reset and operand buses.
//   One instance is selected at a time; only it receives start. A behavioural
//   model (integer multiply plus a WIDTH+2 clock delay) predicts busy, done
//   and product every cycle for the selected instance. Directed cases pin
//   literal products and latency; a randomised phase drives random starts,
//   operands, modes and occasional resets.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [15:0] a, b;
  int          sel;

  logic        busy4, done4, busy8, done8, busy16, done16;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;

  logic        cur_busy, cur_done;
  logic [31:0] cur_prod;
  int          cur_w;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(4)) u_w4 (
    .clk_i(clk), .rst_i(rst), .start_i(start && sel == 0), .is_signed_i(sgn),
    .a_i(a[3:0]), .b_i(b[3:0]), .busy_o(busy4), .done_o(done4), .product_o(p4));
  booth_mult_seq #(.WIDTH(8)) u_w8 (
    .clk_i(clk), .rst_i(rst), .start_i(start && sel == 1), .is_signed_i(sgn),
    .a_i(a[7:0]), .b_i(b[7:0]), .busy_o(busy8), .done_o(done8), .product_o(p8));
  booth_mult_seq #(.WIDTH(16)) u_w16 (
    .clk_i(clk), .rst_i(rst), .start_i(start && sel == 2), .is_signed_i(sgn),
    .a_i(a), .b_i(b), .busy_o(busy16), .done_o(done16), .product_o(p16));

  always_comb begin
    case (sel)
      0: begin cur_w = 4;  cur_busy = busy4;  cur_done = done4;  cur_prod = {24'd0, p4}; end
      1: begin cur_w = 8;  cur_busy = busy8;  cur_done = done8;  cur_prod = {16'd0, p8}; end
      default: begin cur_w = 16; cur_busy = busy16; cur_done = done16; cur_prod = p16; end
    endcase
  end

  // Mathematical product of two w-bit operands, truncated to 2w bits.
  function automatic logic [31:0] ref_mult(input int w, input bit sg,
                                           input logic [15:0] av, input logic [15:0] bv);
    longint m, sa, sb, p;
    m  = (longint'(1) << w) - 1;
    sa = longint'(av) & m;
    sb = longint'(bv) & m;
    if (sg) begin
      if (sa[w-1]) sa = sa - (longint'(1) << w);
      if (sb[w-1]) sb = sb - (longint'(1) << w);
    end
    p = sa * sb;
    p = p & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  // Model: idle unless an operation is pending; result appears WIDTH+2 clocks
  // after the accepting edge, together with a one-cycle done and busy low.
  bit          m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_prod = 32'd0, m_pend = 32'd0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_prod <= 32'd0; m_left <= 0;
    end else if (!m_busy && start) begin
      m_busy <= 1'b1; m_done <= 1'b0; m_left <= cur_w + 1;
      m_pend <= ref_mult(cur_w, sgn, a, b);
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_prod <= m_pend;
      end else begin
        m_done <= 1'b0;
      end
      m_left <= m_left - 1;
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (w=%0d t=%0t): got %h, expected %h", nm, cur_w, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle compare against the model, just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("busy", {31'd0, cur_busy}, {31'd0, m_busy});
      chk("done", {31'd0, cur_done}, {31'd0, m_done});
      chk("product", cur_prod, m_prod);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic switch_to(input int s);
    sel = s; start = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Start one operation at a falling edge, wait for done, check latency and
  // the literal product. hold>0 keeps start high with other operands.
  task automatic op(input bit sg, input logic [15:0] av, input logic [15:0] bv,
                    input logic [31:0] expv, input string nm, input int hold);
    int n;
    bit seen;
    start = 1'b1; sgn = sg; a = av; b = bv;
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n <= hold) begin
        start = 1'b1; a = 16'd100; b = 16'd100;
      end else begin
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); sgn = 1'($urandom);
      end
      seen = cur_done;
    end
    chk({"lat_", nm}, n, cur_w + 2);
    chk({"prod_", nm}, cur_prod, expv);
  endtask

  function automatic logic [15:0] rand_opnd(input int w);
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0: r = 16'(1 << (w - 1));
      1: r = 16'((1 << w) - 1);
      2: r = 16'd0;
      default: r = r;
    endcase
    return r;
  endfunction

  task automatic random_phase(input int s, input int cycles);
    switch_to(s);
    for (int i = 0; i < cycles; i++) begin
      start = ($urandom_range(0, 3) == 0);
      sgn   = 1'($urandom);
      a     = rand_opnd(cur_w);
      b     = rand_opnd(cur_w);
      rst   = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    start = 1'b0; rst = 1'b0;
    idle(20);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = 16'd0; b = 16'd0; sel = 0;
    idle(3);
    rst = 1'b0;
    checking = 1'b1;
    chk("reset_busy", {31'd0, cur_busy}, 32'd0);
    chk("reset_prod", cur_prod, 32'd0);

    // WIDTH 4 directed
    op(1'b1, 16'h3, 16'h2, 32'h06, "s3x2", 0);
    op(1'b1, 16'hD, 16'h3, 32'hF7, "sm3x3", 0);
    op(1'b1, 16'h4, 16'hC, 32'hF0, "s4xm4", 0);
    op(1'b1, 16'hF, 16'hF, 32'h01, "sm1xm1", 0);
    op(1'b1, 16'h8, 16'h8, 32'h40, "sm8xm8", 0);
    idle(2);
    op(1'b0, 16'hF, 16'hF, 32'hE1, "uFxF", 0);
    op(1'b0, 16'h8, 16'h2, 32'h10, "u8x2", 0);
    op(1'b1, 16'h8, 16'h2, 32'hF0, "s8x2", 0);
    idle(3);

    // WIDTH 8: start while busy, back-to-back, reset mid-operation
    switch_to(1);
    op(1'b1, 16'd7, 16'd9, 32'd63, "busy_ign", 5);
    idle(12);
    op(1'b1, 16'd5, 16'd5, 32'd25, "b2b_1", 0);
    op(1'b1, 16'h80, 16'h7F, 32'hC080, "b2b_2", 0);
    start = 1'b1; sgn = 1'b0; a = 16'd200; b = 16'd201;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    idle(3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, cur_busy}, 32'd0);
    chk("rst_done", {31'd0, cur_done}, 32'd0);
    chk("rst_prod", cur_prod, 32'd0);
    idle(15);
    op(1'b1, 16'd6, 16'hF9, 32'hFFD6, "after_rst", 0);
    idle(3);

    // Randomised phases
    random_phase(0, 6000);
    random_phase(1, 16000);
    random_phase(2, 20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
